// File: rtl/count_mod10_ctrl.sv
// Command sequencer and two-port round-robin arbiter driving a mod-10 up/down counter.
// Keeps a shadow of the expected count and flags LOAD range errors or counter disagreement.
module count_mod10_ctrl #(
    parameter int NUM_REQ = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*NUM_REQ-1:0]   req_op,
    input  logic [4*NUM_REQ-1:0]   req_arg,
    output logic                   ctr_load,
    output logic                   ctr_mode,
    output logic [3:0]             ctr_data_in,
    input  logic [3:0]             ctr_data_out,
    output logic                   done,
    output logic                   done_id,
    output logic [3:0]             done_count,
    output logic                   done_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [1:0] state;
    logic [3:0] shadow;
    logic [3:0] rem;
    logic [3:0] arg_q;
    logic [1:0] op_q;
    logic       id_q;
    logic       rr;
    logic       err_q;

    logic       gnt_id;
    logic       hs;
    logic [1:0] sel_op;
    logic [3:0] sel_arg;
    logic       step_op;
    logic [3:0] shadow_step;

    always_comb begin
        gnt_id    = 1'b0;
        req_ready = '0;
        case (req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = rr;
            default: gnt_id = 1'b0;
        endcase
        hs = (state == S_IDLE) && (req_valid != '0);
        if (hs) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign sel_op  = gnt_id ? req_op[3:2]  : req_op[1:0];
    assign sel_arg = gnt_id ? req_arg[7:4] : req_arg[3:0];

    // Zero-step UP/DOWN behaves as a single hold cycle, like a rejected LOAD.
    assign step_op = ((op_q == OP_UP) || (op_q == OP_DOWN)) && (rem != 4'd0);

    always_comb begin
        shadow_step = shadow;
        if (op_q == OP_UP) begin
            shadow_step = (shadow == 4'd9) ? 4'd0 : shadow + 4'd1;
        end else begin
            shadow_step = (shadow == 4'd0) ? 4'd9 : shadow - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            shadow <= '0;
            rem    <= '0;
            arg_q  <= '0;
            op_q   <= OP_LOAD;
            id_q   <= 1'b0;
            rr     <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        op_q  <= sel_op;
                        arg_q <= sel_arg;
                        rem   <= sel_arg;
                        id_q  <= gnt_id;
                        rr    <= ~gnt_id;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    err_q <= (op_q == OP_LOAD) && (arg_q > 4'd9);
                    case (op_q)
                        OP_LOAD:  if (arg_q <= 4'd9) shadow <= arg_q;
                        OP_CLEAR: shadow <= '0;
                        default:  if (step_op) shadow <= shadow_step;
                    endcase
                    if (step_op && (rem > 4'd1)) begin
                        rem <= rem - 4'd1;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outside an active step the counter is always reloaded, so it cannot drift.
    always_comb begin
        ctr_load    = 1'b1;
        ctr_mode    = 1'b0;
        ctr_data_in = shadow;
        if (state == S_EXEC) begin
            case (op_q)
                OP_LOAD:  if (arg_q <= 4'd9) ctr_data_in = arg_q;
                OP_CLEAR: ctr_data_in = '0;
                default: begin
                    if (step_op) begin
                        ctr_load = 1'b0;
                        ctr_mode = (op_q == OP_UP);
                    end
                end
            endcase
        end
    end

    assign done       = (state == S_DONE);
    assign done_id    = done & id_q;
    assign done_count = done ? shadow : '0;
    assign done_err   = done & (err_q | (ctr_data_out != shadow));

endmodule

// File: tb/tb_count_mod10_ctrl.sv
// Bench for count_mod10_ctrl: behavioural mod-10 counter, arithmetic reference model,
// and a done-scoreboard monitor; directed test-plan scenarios followed by random traffic.
module tb_count_mod10_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       v0 = 1'b0, v1 = 1'b0;
    logic [1:0] o0 = '0, o1 = '0;
    logic [3:0] a0 = '0, a1 = '0;

    logic [1:0] req_valid, req_ready;
    logic [3:0] req_op;
    logic [7:0] req_arg;
    logic       ctr_load, ctr_mode;
    logic [3:0] ctr_data_in, ctr_data_out;
    logic       done, done_id, done_err;
    logic [3:0] done_count;

    assign req_valid = {v1, v0};
    assign req_op    = {o1, o0};
    assign req_arg   = {a1, a0};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int bad_edge = -1;
    logic [3:0] cnt = '0;

    typedef struct {
        int id;
        int count;
        int err;
        int at;
    } exp_t;
    exp_t sb[$];

    int m_val = 0, m_rr = 0, m_idle_at = 0;
    int m_base = 0, m_dir = 0, m_E = 0, m_L = 0;
    int m_bad_at = -1, m_bad_val = 0;
    bit m_corrupt_next = 1'b0;

    count_mod10_ctrl #(.NUM_REQ(2)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_arg      (req_arg),
        .ctr_load     (ctr_load),
        .ctr_mode     (ctr_mode),
        .ctr_data_in  (ctr_data_in),
        .ctr_data_out (ctr_data_out),
        .done         (done),
        .done_id      (done_id),
        .done_count   (done_count),
        .done_err     (done_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Counter value expected in the cycle after edge c.
    function automatic int exp_ctr(input int c);
        if (c == m_bad_at) return m_bad_val;
        if (c >= m_E && c < m_E + m_L) begin
            if (m_dir == 0) return m_base;
            return (m_base + 160 + m_dir * (c - m_E)) % 10;
        end
        return m_val;
    endfunction

    // Behavioural count_mod10; can be corrupted at a chosen edge.
    assign ctr_data_out = cnt;
    always @(posedge clock) begin : counter_model
        int nx;
        if (ctr_load) nx = int'(ctr_data_in);
        else if (ctr_mode) nx = (cnt == 4'd9) ? 0 : int'(cnt) + 1;
        else nx = (cnt == 4'd0) ? 9 : int'(cnt) - 1;
        if (bad_edge == cyc + 1) nx = (nx + 5) % 10;
        cnt <= 4'(nx);
        cyc <= cyc + 1;
    end

    // Reference model: predicts grants, counter trajectory and completions.
    always @(negedge clock) begin : ref_model
        int g, op, arg, L, nv, err, E;
        logic [1:0] er;
        if (!reset) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_load", ctr_load, 1);
            chk("rst_mode", ctr_mode, 0);
            chk("rst_din", ctr_data_in, 0);
            chk("rst_done", {done, done_id, done_count, done_err}, 0);
            m_val = 0; m_rr = 0; m_idle_at = 0; m_L = 0; m_bad_at = -1;
            bad_edge = -1;
            sb.delete();
        end else begin
            chk("ctr_value", cnt, exp_ctr(cyc));
            er = 2'b00;
            g = 0;
            if (cyc >= m_idle_at && req_valid != 2'b00) begin
                g  = (req_valid == 2'b11) ? m_rr : (req_valid[1] ? 1 : 0);
                er = (g == 1) ? 2'b10 : 2'b01;
            end
            chk("req_ready", req_ready, er);
            if (er != 2'b00) begin
                op  = g ? int'(req_op[3:2]) : int'(req_op[1:0]);
                arg = g ? int'(req_arg[7:4]) : int'(req_arg[3:0]);
                E = cyc + 1;
                err = 0;
                m_base = m_val;
                m_dir = 0;
                L = 1;
                nv = m_val;
                case (op)
                    0: begin
                        if (arg <= 9) nv = arg;
                        else err = 1;
                    end
                    1: begin
                        L = (arg == 0) ? 1 : arg;
                        m_dir = (arg == 0) ? 0 : 1;
                        nv = (m_val + arg) % 10;
                    end
                    2: begin
                        L = (arg == 0) ? 1 : arg;
                        m_dir = (arg == 0) ? 0 : -1;
                        nv = (m_val + 20 - arg) % 10;
                    end
                    default: nv = 0;
                endcase
                m_E = E;
                m_L = L;
                m_val = nv;
                m_idle_at = E + L + 1;
                m_rr = 1 - g;
                m_bad_at = -1;
                if (m_corrupt_next) begin
                    m_corrupt_next = 1'b0;
                    err = 1;
                    m_bad_at = E + L;
                    m_bad_val = (nv + 5) % 10;
                    bad_edge = E + L;
                end
                sb.push_back('{g, nv, err, E + L});
            end
        end
    end

    // Completion monitor: pops the scoreboard whenever the DUT reports done.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_spurious", done, 0);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", done_id, e.id);
                    chk("done_count", done_count, e.count);
                    chk("done_err", done_err, e.err);
                    chk("done_cycle", cyc, e.at);
                end
            end else if (sb.size() > 0 && cyc > sb[0].at) begin
                chk("done_missing", done, 1);
                e = sb.pop_front();
            end
        end
    end

    task automatic set_req(input int id, input logic val, input int op, input int arg);
        if (id == 0) begin v0 = val; o0 = 2'(op); a0 = 4'(arg); end
        else begin v1 = val; o1 = 2'(op); a1 = 4'(arg); end
    endtask

    task automatic send(input int id, input int op, input int arg, input bit keep);
        int w;
        bit acc;
        set_req(id, 1'b1, op, arg);
        acc = 1'b0;
        w = 0;
        while (!acc && w < 100) begin
            @(negedge clock);
            acc = req_ready[id];
            @(posedge clock);
            #1;
            w++;
        end
        chk($sformatf("accept_r%0d", id), acc, 1);
        if (!keep) set_req(id, 1'b0, op, arg);
    endtask

    task automatic rand_driver(input int id, input int n);
        int op, arg;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clock);
                #1;
            end
            op  = $urandom_range(0, 3);
            arg = $urandom_range(0, 15);
            if ($urandom_range(0, 7) == 0) begin
                set_req(id, 1'b1, op, arg);
                @(posedge clock);
                #1;
                set_req(id, 1'b0, op, arg);
            end else begin
                send(id, op, arg, 1'b0);
            end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int w;
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        send(0, 0, 7, 1'b0);
        repeat (12) @(posedge clock);
        #1;
        chk("hold7", cnt, 7);

        send(0, 0, 8, 1'b0);
        send(1, 1, 5, 1'b0);
        send(0, 3, 0, 1'b0);
        send(1, 2, 3, 1'b0);
        send(0, 1, 0, 1'b0);
        send(0, 0, 12, 1'b0);
        m_corrupt_next = 1'b1;
        send(1, 0, 3, 1'b0);
        repeat (5) @(posedge clock);
        #1;

        // Reset lands while the third step of UP 9 would be executing.
        send(0, 1, 9, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        @(posedge clock);
        #2 reset = 1'b1;
        chk("ctr_after_reset", cnt, 0);

        fork
            begin send(0, 1, 1, 1'b1); send(0, 1, 1, 1'b0); end
            begin send(1, 1, 1, 1'b1); send(1, 1, 1, 1'b0); end
        join
        repeat (5) @(posedge clock);
        #1;

        fork
            rand_driver(0, 20);
            rand_driver(1, 20);
        join

        w = 0;
        while (sb.size() > 0 && w < 100) begin
            @(posedge clock);
            w++;
        end
        repeat (3) @(posedge clock);
        chk("drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/count_mod10_ctrl.md
# count_mod10_ctrl

Command sequencer and two-port round-robin arbiter for the `count_mod10` up/down counter. It accepts LOAD, UP, DOWN and CLEAR commands from two requesters over valid/ready handshakes. It drives the counter's `load`, `mode` and `data_in` to execute each command, and keeps a shadow of the expected count. On completion it reports the count and an error flag, and it holds the counter stable between commands.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters; fixed, other values are not supported.

Ports:
- `clock`  in  1  single clock; everything is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester command valid.
- `req_ready`  out  2  per-requester accept; at most one bit is high.
- `req_op`  in  4  `{op1[1:0], op0[1:0]}` with encoding 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR.
- `req_arg`  in  8  `{arg1[3:0], arg0[3:0]}`. For LOAD this is the value; for UP/DOWN it is the step count 0..15; CLEAR ignores it.
- `ctr_load`  out  1  to counter `load`.
- `ctr_mode`  out  1  to counter `mode`; 1 = up, 0 = down.
- `ctr_data_in`  out  4  to counter `data_in`.
- `ctr_data_out`  in  4  from counter `data_out`.
- `done`  out  1  one-cycle completion pulse.
- `done_id`  out  1  requester that owned the completed command.
- `done_count`  out  4  shadow count at completion.
- `done_err`  out  1  error flag: LOAD argument > 9, or the counter disagrees with the shadow.

## Operation
- Counter model:
  - `load` = 1 loads `data_in` at the clock edge.
  - `load` = 0 counts one step per edge in the direction given by `mode`.
  - Up wraps 9 -> 0; down wraps 0 -> 9.
- States: IDLE, EXEC, DONE.
- Hold rule: in IDLE and DONE the block drives `ctr_load` = 1 and `ctr_data_in` = shadow, so the counter never free-runs.
- IDLE:
  - If only one `req_valid` bit is high, that requester is granted.
  - If both are high, the requester selected by the round-robin pointer `rr` is granted.
  - `req_ready[g]` = 1, combinationally, for the granted requester only.
  - On handshake the block latches op, arg and id, moves `rr` to the other requester, and goes to EXEC.
- EXEC:
  - LOAD with arg <= 9: one cycle of `ctr_load` = 1, `ctr_data_in` = arg; shadow <= arg.
  - LOAD with arg > 9: one hold cycle; shadow is unchanged and the error is latched.
  - CLEAR: one cycle of `ctr_load` = 1, `ctr_data_in` = 0; shadow <= 0.
  - UP/DOWN with n >= 1: n cycles of `ctr_load` = 0 and `ctr_mode` = 1 (UP) or 0 (DOWN). Shadow steps mod 10 in lockstep. A 4-bit down-counter tracks the remaining steps.
  - UP/DOWN with n = 0: one hold cycle; no count change.
  - The block then goes to DONE.
- DONE:
  - `done` = 1 with `done_id`, `done_count` = shadow, and `done_err` = latched error OR (`ctr_data_out` != shadow).
  - The block goes to IDLE next cycle.
- Mismatch handling: `done_err` is set, but the shadow is kept. The following hold cycles force the counter back to the shadow value.

## Timing
- Reset (asynchronous assert) forces:
  - state IDLE, shadow 0, `rr` 0;
  - `req_ready` 0, `ctr_load` 1, `ctr_mode` 0, `ctr_data_in` 0;
  - `done`, `done_id`, `done_count`, `done_err` all 0.
- Reset deassert: outputs are stable from the first edge after deassertion.
- Reset mid-command: the command is abandoned with no `done`. The counter is reloaded to 0 at the next edge.
- Latency, with the handshake at edge E:
  - EXEC runs for max(n, 1) cycles, from after E to edge E+max(n,1).
  - `done` is high in the cycle after edge E+max(n,1).
  - IDLE resumes at edge E+max(n,1)+1.
  - Example: LOAD gives `done` two cycles after the handshake edge.
- Handshake rules:
  - No command is accepted in EXEC or DONE.
  - The earliest next accept is the first IDLE cycle after `done`.
  - `req_valid` may drop without being accepted; nothing is latched.
- Fairness: under continuous contention, grants alternate 0, 1, 0, 1, ... The first contended grant after reset goes to requester 0.
- Output registration: `ctr_*` are decoded from registered state and the latched op, with no combinational path from `req_*`. `req_ready` is combinational from `req_valid` and state.

## Test plan
- Reset, then requester 0 sends LOAD 7 -> `ctr_load` = 1 with `ctr_data_in` = 7 for one cycle; `done` = 1, `done_id` = 0, `done_count` = 7, `done_err` = 0; counter holds at 7 for 10 idle cycles.
- LOAD 8, then UP 5 -> counter sequence 9, 0, 1, 2, 3; `done_count` = 3; `done` occurs 6 cycles after the UP handshake edge.
- CLEAR, then DOWN 3 -> counter sequence 9, 8, 7; `done_count` = 7. Then UP 0 -> `done` two cycles after the handshake edge, `done_count` = 7, count unchanged.
- Both requesters hold `req_valid` continuously with UP 1 each -> grant order 0, 1, 0, 1; `req_ready` is never 2'b11; four `done` pulses with `done_count` 1, 2, 3, 4 starting from 0.
- LOAD 12 -> `done_err` = 1, `done_count` equals the prior value. A bench-forced `ctr_data_out` mismatch during DONE -> `done_err` = 1, and the counter is reloaded to the shadow value on the next edge.
- `reset` pulsed low during the third step of UP 9 -> no `done`; `ctr_load` = 1 with `ctr_data_in` = 0; counter reads 0 after the next edge; the next command is accepted normally.
